// File: rtl/salida_uart_pkg.sv
// Shared constants and FSM encoding for the Salida result reporter UART.
package salida_uart_pkg;

  localparam logic [7:0] HEADER_BYTE     = 8'hA5;
  localparam int         BYTES_PER_FRAME = 9;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;

endpackage

// File: rtl/salida_fifo.sv
// Synchronous FIFO for captured result words; a write while full is
// accepted only when a read happens on the same edge.
module salida_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic             rd_en,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_wr;
  logic             do_rd;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign do_rd = rd_en && !empty;
  assign do_wr = wr_en && (!full || do_rd);
  assign rdata = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + AW'(1);
      if (do_rd) rd_ptr <= rd_ptr + AW'(1);
      case ({do_wr, do_rd})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: pointers and count define validity.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/salida_uart_tx.sv
// Captures each new value of the core's Salida bus and streams it out as a
// 9-byte 8N1 frame: header 0xA5 followed by the word, least significant byte first.
module salida_uart_tx
  import salida_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        Reset,
  input  logic [63:0] Salida,
  input  logic        en,
  output logic        tx,
  output logic        busy,
  output logic        overflow,
  output logic [15:0] frame_count,
  output tx_state_e   dbg_state
);

  localparam logic [15:0] BIT_RELOAD = 16'(CLKS_PER_BIT - 1);
  localparam logic [3:0]  LAST_BYTE  = 4'(BYTES_PER_FRAME - 1);

  tx_state_e   state;
  logic [63:0] last_q;
  logic [63:0] word_q;
  logic [7:0]  shift_q;
  logic [15:0] timer_q;
  logic [2:0]  bit_idx;
  logic [3:0]  byte_idx;

  logic        capture;
  logic        pop;
  logic        fifo_full;
  logic        fifo_empty;
  logic [63:0] fifo_rdata;

  assign capture   = en && (Salida != last_q);
  assign pop       = (state == IDLE) && !fifo_empty;
  assign dbg_state = state;

  salida_fifo #(
    .WIDTH (64),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (Reset),
    .wr_en (capture),
    .rd_en (pop),
    .wdata (Salida),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // last_q follows every capture, dropped or not, so a dropped value is not retried.
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      last_q   <= '0;
      overflow <= 1'b0;
    end else begin
      if (capture) last_q <= Salida;
      if (capture && fifo_full && !pop) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      state       <= IDLE;
      tx          <= 1'b1;
      busy        <= 1'b0;
      word_q      <= '0;
      shift_q     <= '0;
      timer_q     <= '0;
      bit_idx     <= '0;
      byte_idx    <= '0;
      frame_count <= '0;
    end else begin
      busy <= !fifo_empty || (state != IDLE);
      case (state)
        IDLE: begin
          if (!fifo_empty) begin
            word_q   <= fifo_rdata;
            shift_q  <= HEADER_BYTE;
            byte_idx <= '0;
            timer_q  <= BIT_RELOAD;
            tx       <= 1'b0;
            state    <= START;
          end
        end
        START: begin
          if (timer_q == '0) begin
            timer_q <= BIT_RELOAD;
            tx      <= shift_q[0];
            bit_idx <= '0;
            state   <= DATA;
          end else begin
            timer_q <= timer_q - 16'd1;
          end
        end
        DATA: begin
          if (timer_q == '0) begin
            timer_q <= BIT_RELOAD;
            if (bit_idx == 3'd7) begin
              tx    <= 1'b1;
              state <= STOP;
            end else begin
              tx      <= shift_q[1];
              shift_q <= shift_q >> 1;
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            timer_q <= timer_q - 16'd1;
          end
        end
        STOP: begin
          if (timer_q == '0) begin
            if (byte_idx < LAST_BYTE) begin
              byte_idx <= byte_idx + 4'd1;
              shift_q  <= word_q[7:0];
              word_q   <= word_q >> 8;
              timer_q  <= BIT_RELOAD;
              tx       <= 1'b0;
              state    <= START;
            end else begin
              frame_count <= frame_count + 16'd1;
              state       <= IDLE;
            end
          end else begin
            timer_q <= timer_q - 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
